da_sequencer: RTL and testbench
===============================

Name: da_sequencer

Overview:
- Frame controller for the 4-phase distributed-arithmetic decode datapath: 16-bit input-bit vector → 4 lookup phases → ROM → accumulator.
- Accepts one 16-bit X frame per valid/ready handshake and drives the phase select and 4-bit ROM address nibble for each phase.
- Generates accumulator clear/enable, waits out the ROM+accumulator latency, then captures the 28-bit result into an output holding register with valid/ready backpressure.
- Replaces the free-running phase counter so that phase 0 is always aligned to the start of a frame.

Parameters:
- XW, 16, total input bits per frame; must equal PHASES*4.
- PHASES, 4, lookup phases per frame.
- LAT, 2, cycles from the last phase's address to a settled accumulator output (ROM reg + AC reg); valid range 1..7.
- YW, 28, result width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  X frame offered.
- in_ready  out  1  frame accepted when in_valid&&in_ready at a rising edge.
- in_x  in  XW  input bit vector (bit i = tap i).
- phase  out  2  phase select to coefficient muxes.
- x_sel  out  4  ROM address nibble = x_reg[4*phase+3 : 4*phase].
- acc_clr  out  1  accumulator loads instead of adding (first phase).
- acc_en  out  1  accumulator updates this cycle.
- acc_y  in  YW  accumulator output.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts result.
- out_y  out  YW  held result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; phase=0; x_sel=0; acc_clr=0; acc_en=0; out_valid=0; out_y=0; x_reg=0; drain counter=0. Reset mid-frame discards the frame silently.
- States: IDLE, RUN, DRAIN, HOLD. All outputs are registered except in_ready.
- in_ready is combinational: 1 in IDLE, out_ready in HOLD, 0 in RUN and DRAIN.
- IDLE: on accept, capture in_x→x_reg, phase←0, go RUN.
- RUN, one cycle per phase p=0..PHASES-1:
  - acc_en=1; acc_clr=1 only when p=0.
  - x_sel is driven from x_reg at the current phase.
  - At p=PHASES-1, go DRAIN with counter←LAT.
- DRAIN: acc_en=0, acc_clr=0, phase holds at PHASES-1. Decrement the counter; on the cycle the counter reads 1, capture acc_y→out_y and go HOLD with out_valid=1.
- HOLD:
  - out_valid=1 and out_y stable until out_ready.
  - out_ready && !in_valid → out_valid←0, go IDLE.
  - out_ready && in_valid → accept the new frame in the same cycle, out_valid←0, go RUN with phase←0. This is back-to-back operation with no idle bubble.
- Latency (LAT=2): accept edge at cycle 0; RUN cycles 1-4; DRAIN cycles 5-6; out_valid high from cycle 7. In general, out_valid rises PHASES+LAT+1 cycles after accept.
- Throughput: one frame per PHASES+LAT+1 cycles when out_ready is held high.
- in_x changes after accept have no effect; x_reg is only loaded on accept.
- out_ready while out_valid=0 is ignored.
- in_valid is not required to stay high without ready.
- phase wraps only through a new accept, never free-runs.

Decomposition:
- Shared package da_pkg:
  - state enum (IDLE/RUN/DRAIN/HOLD);
  - constants PHASES, XW, YW, LAT default;
  - function nib_sel(x, p) returning the 4-bit slice.
- One natural sub-module: da_out_hold, the YW-wide output register with valid/ready and a capture strobe. Everything else stays inline.

Test Plan:
- Reset mid-RUN (assert rst_n low during phase 2) → all outputs zero immediately; after release, busy=0 and in_ready=1.
- Single frame in_x=16'hA5C3, out_ready=1:
  - x_sel sequence 3,C,5,A on cycles 1-4.
  - acc_clr=1 only on cycle 1; acc_en=1 on cycles 1-4.
  - acc_y model=28'h0123456 at cycle 6 → out_valid cycle 7, out_y=28'h0123456.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_y stable, in_ready=0 throughout; out_ready=1 → out_valid drops next cycle.
- Back-to-back: frames 16'hFFFF then 16'h0001 with in_valid and out_ready held high → second frame's RUN starts the cycle after first out_valid; x_sel 1,0,0,0; no idle cycle.
- LAT=4 build: single frame → out_valid at cycle 9; acc_y sampled at cycle 8.
- in_x toggling during RUN → x_sel follows the captured x_reg only.

Source files
------------

// File: rtl/da_pkg.sv
// Shared types, sizing constants and the nibble-select helper for the
// distributed-arithmetic frame sequencer.
package da_pkg;

    localparam int PHASES  = 4;
    localparam int XW      = 16;
    localparam int YW      = 28;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic logic [3:0] nib_sel(input logic [XW-1:0] x, input logic [1:0] p);
        return x[{p, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/da_sequencer_if.sv
// Frame handshake, ROM/accumulator control and result handshake of the
// DA sequencer, bundled for the top-level port list.
interface da_sequencer_if;

    logic                    in_valid;
    logic                    in_ready;
    logic [da_pkg::XW-1:0]   in_x;
    logic [1:0]              phase;
    logic [3:0]              x_sel;
    logic                    acc_clr;
    logic                    acc_en;
    logic [da_pkg::YW-1:0]   acc_y;
    logic                    out_valid;
    logic                    out_ready;
    logic [da_pkg::YW-1:0]   out_y;
    logic                    busy;

    modport slave (
        input  in_valid, in_x, acc_y, out_ready,
        output in_ready, phase, x_sel, acc_clr, acc_en, out_valid, out_y, busy
    );

    modport master (
        output in_valid, in_x, acc_y, out_ready,
        input  in_ready, phase, x_sel, acc_clr, acc_en, out_valid, out_y, busy
    );

endinterface

// File: rtl/da_out_hold.sv
// Result holding register: loads on a capture strobe, keeps valid and data
// steady until released by the downstream handshake.
module da_out_hold
    import da_pkg::*;
#(
    parameter int W = YW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_i,
    input  logic         rel_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] y_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] y_q, y_d;

    // Capture wins over release; a release with nothing held is harmless.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        if (cap_i) begin
            valid_d = 1'b1;
            y_d     = d_i;
        end else if (rel_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign y_o     = y_q;

endmodule

// File: rtl/da_sequencer.sv
// Frame controller for the 4-phase DA datapath: sequences ROM address nibbles,
// drives accumulator clear/enable, waits out pipeline latency, holds the result.
module da_sequencer
    import da_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    da_sequencer_if.slave  bus
);

    localparam logic [1:0] PH_LAST = 2'(PHASES - 1);
    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [3:0]      x_sel_q, x_sel_d;
    logic            acc_clr_q, acc_clr_d;
    logic            acc_en_q, acc_en_d;
    logic            busy_q, busy_d;
    logic [XW-1:0]   x_q, x_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            in_ready_s;
    logic            accept_s;
    logic            cap_s;
    logic            rel_s;

    // Next-state and registered-output decode for the frame FSM.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        x_sel_d    = x_sel_q;
        acc_clr_d  = 1'b0;
        acc_en_d   = 1'b0;
        x_d        = x_q;
        cnt_d      = cnt_q;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        cap_s      = 1'b0;
        rel_s      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                accept_s   = bus.in_valid;
            end
            RUN: begin
                if (phase_q == PH_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = LAT_CNT;
                end else begin
                    phase_d  = phase_q + 2'd1;
                    x_sel_d  = nib_sel(x_q, phase_q + 2'd1);
                    acc_en_d = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd1) begin
                    cap_s   = 1'b1;
                    state_d = HOLD;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HOLD: begin
                in_ready_s = bus.out_ready;
                if (bus.out_ready) begin
                    rel_s    = 1'b1;
                    accept_s = bus.in_valid;
                    state_d  = IDLE;
                end else begin
                    rel_s = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept (from IDLE or straight out of HOLD) always restarts at phase 0.
        if (accept_s) begin
            state_d   = RUN;
            x_d       = bus.in_x;
            phase_d   = 2'd0;
            x_sel_d   = nib_sel(bus.in_x, 2'd0);
            acc_clr_d = 1'b1;
            acc_en_d  = 1'b1;
        end else begin
            x_d = x_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            x_sel_q   <= 4'd0;
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            x_q       <= '0;
            cnt_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            x_sel_q   <= x_sel_d;
            acc_clr_q <= acc_clr_d;
            acc_en_q  <= acc_en_d;
            busy_q    <= busy_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
        end
    end

    da_out_hold #(.W(YW)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap_i   (cap_s),
        .rel_i   (rel_s),
        .d_i     (bus.acc_y),
        .valid_o (bus.out_valid),
        .y_o     (bus.out_y)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.phase    = phase_q;
    assign bus.x_sel    = x_sel_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.acc_en   = acc_en_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_da_sequencer.sv
// Directed bench for da_sequencer: a per-cycle vector table for one frame plus
// hand-written reset, backpressure, back-to-back and LAT=4 sequences.
module tb_da_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    da_sequencer_if bus ();
    da_sequencer_if bus4 ();

    da_sequencer #(.LAT(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    da_sequencer #(.LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    typedef struct {
        logic        iv;
        logic [15:0] ix;
        logic        ordy;
        logic [27:0] ay;
        logic [1:0]  ph;
        logic [3:0]  xs;
        logic        clr;
        logic        en;
        logic        ov;
        logic        ir;
        logic        bz;
        logic [27:0] oy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int first;
        logic [27:0] y_hold;

        bus.in_valid = 1'b0;  bus.in_x = 16'h0000;  bus.out_ready = 1'b0;  bus.acc_y = 28'h0000000;
        bus4.in_valid = 1'b0; bus4.in_x = 16'h0000; bus4.out_ready = 1'b0; bus4.acc_y = 28'h0000000;

        // Reset state
        step();
        chk("rst phase", 32'(bus.phase), 32'h0);
        chk("rst x_sel", 32'(bus.x_sel), 32'h0);
        chk("rst acc_en", 32'(bus.acc_en), 32'h0);
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst in_ready", 32'(bus.in_ready), 32'h1);
        rst_n = 1'b1;
        step();

        // Single frame A5C3, one row per cycle; in_x scrambled after accept
        tbl[0] = '{1'b1, 16'hA5C3, 1'b1, 28'hBAD0000, 2'd0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 28'hBAD0000, 2'd1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[2] = '{1'b1, 16'hFFFF, 1'b1, 28'hBAD0000, 2'd2, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[3] = '{1'b0, 16'h1234, 1'b1, 28'hBAD0000, 2'd3, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[4] = '{1'b0, 16'h1234, 1'b1, 28'hBAD0000, 2'd3, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[5] = '{1'b0, 16'h1234, 1'b1, 28'hBAD0000, 2'd3, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0};
        tbl[6] = '{1'b0, 16'h1234, 1'b1, 28'h0123456, 2'd3, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 28'h0123456};
        tbl[7] = '{1'b0, 16'h1234, 1'b1, 28'hBAD0000, 2'd3, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0123456};

        for (int r = 0; r < 8; r++) begin
            bus.in_valid  = tbl[r].iv;
            bus.in_x      = tbl[r].ix;
            bus.out_ready = tbl[r].ordy;
            bus.acc_y     = tbl[r].ay;
            step();
            chk($sformatf("c%0d phase", r + 1), 32'(bus.phase), 32'(tbl[r].ph));
            chk($sformatf("c%0d x_sel", r + 1), 32'(bus.x_sel), 32'(tbl[r].xs));
            chk($sformatf("c%0d acc_clr", r + 1), 32'(bus.acc_clr), 32'(tbl[r].clr));
            chk($sformatf("c%0d acc_en", r + 1), 32'(bus.acc_en), 32'(tbl[r].en));
            chk($sformatf("c%0d out_valid", r + 1), 32'(bus.out_valid), 32'(tbl[r].ov));
            chk($sformatf("c%0d in_ready", r + 1), 32'(bus.in_ready), 32'(tbl[r].ir));
            chk($sformatf("c%0d busy", r + 1), 32'(bus.busy), 32'(tbl[r].bz));
            chk($sformatf("c%0d out_y", r + 1), 32'(bus.out_y), 32'(tbl[r].oy));
        end

        // Reset asserted during phase 2
        bus.in_valid = 1'b1; bus.in_x = 16'h5A5A; bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("pre-rst phase", 32'(bus.phase), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("midrst phase", 32'(bus.phase), 32'h0);
        chk("midrst x_sel", 32'(bus.x_sel), 32'h0);
        chk("midrst acc_en", 32'(bus.acc_en), 32'h0);
        chk("midrst out_y", 32'(bus.out_y), 32'h0);
        chk("midrst busy", 32'(bus.busy), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("postrst busy", 32'(bus.busy), 32'h0);
        chk("postrst in_ready", 32'(bus.in_ready), 32'h1);

        // Backpressure: hold result 10 cycles while acc_y keeps moving
        bus.in_valid = 1'b1; bus.in_x = 16'hA5C3; bus.acc_y = 28'h0ABCDEF;
        step();
        bus.in_valid = 1'b0;
        k = 1;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk("bp latency", 32'(k), 32'd7);
        y_hold = bus.out_y;
        chk("bp out_y", 32'(y_hold), 32'h0ABCDEF);
        for (int i = 0; i < 10; i++) begin
            bus.acc_y = 28'(i * 28'h0101011);
            bus.in_valid = i[0];
            #1;
            chk($sformatf("bp in_ready %0d", i), 32'(bus.in_ready), 32'h0);
            step();
            chk($sformatf("bp out_valid %0d", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("bp out_y %0d", i), 32'(bus.out_y), 32'h0ABCDEF);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("bp release out_valid", 32'(bus.out_valid), 32'h0);
        chk("bp release busy", 32'(bus.busy), 32'h0);

        // Back-to-back frames FFFF then 0001
        bus.in_valid = 1'b1; bus.in_x = 16'hFFFF; bus.acc_y = 28'h1111111;
        step();
        chk("b2b f1 x_sel", 32'(bus.x_sel), 32'hF);
        bus.in_x = 16'h0001;
        k = 1;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk("b2b f1 latency", 32'(k), 32'd7);
        chk("b2b f1 out_y", 32'(bus.out_y), 32'h1111111);
        chk("b2b in_ready", 32'(bus.in_ready), 32'h1);
        bus.acc_y = 28'h2222222;
        step();
        chk("b2b f2 out_valid", 32'(bus.out_valid), 32'h0);
        chk("b2b f2 busy", 32'(bus.busy), 32'h1);
        chk("b2b f2 phase", 32'(bus.phase), 32'h0);
        chk("b2b f2 acc_clr", 32'(bus.acc_clr), 32'h1);
        chk("b2b f2 x_sel0", 32'(bus.x_sel), 32'h1);
        bus.in_valid = 1'b0;
        for (int p = 1; p < 4; p++) begin
            step();
            chk($sformatf("b2b f2 x_sel%0d", p), 32'(bus.x_sel), 32'h0);
        end
        k = 0;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk("b2b f2 tail", 32'(k), 32'd3);
        chk("b2b f2 out_y", 32'(bus.out_y), 32'h2222222);
        step();
        chk("b2b end busy", 32'(bus.busy), 32'h0);

        // LAT=4 instance: acc_y only correct during cycle 8
        bus4.in_valid = 1'b1; bus4.in_x = 16'h1234; bus4.out_ready = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus4.out_valid) begin
                first = c;
                break;
            end
            bus4.acc_y = (c == 8) ? 28'h0FEDCBA : 28'hBAD0000;
            step();
        end
        chk("lat4 out_valid cycle", 32'(first), 32'd9);
        chk("lat4 out_y", 32'(bus4.out_y), 32'h0FEDCBA);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
